bloom_ctrl: RTL

Sequencer and two-port arbiter in front of the Bloom filter datapath. Two requesters share one filter instance. The block grants one requester at a time, drives the filter's insert/check/data/reset controls, waits out the comparator latency, and returns a per-requester response. It also owns filter clearing (on request and automatically after reset) and tracks insert occupancy so software can detect saturation.

---
 rtl/bloom_ctrl.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/bloom_ctrl.sv
// bloom_ctrl: round-robin arbiter and sequencer in front of a Bloom filter.
// Two requesters share one filter. The block grants one transaction at a
// time, waits out the comparator latency, returns a per-requester response,
// owns filter clearing and tracks insert occupancy.
module bloom_ctrl #(
  parameter int DataWidth    = 9,
  parameter int CheckLatency = 2,
  parameter int MaxInserts   = 16,
  parameter int ClearCycles  = 2
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic [1:0]                        req_i,
  input  logic [1:0]                        op_i,
  input  logic [DataWidth-1:0]              data0_i,
  input  logic [DataWidth-1:0]              data1_i,
  output logic [1:0]                        gnt_o,
  output logic [1:0]                        rsp_valid_o,
  output logic                              rsp_match_o,
  output logic                              rsp_err_o,
  input  logic                              clear_req_i,
  output logic                              clear_done_o,
  output logic                              bf_insert_o,
  output logic                              bf_check_o,
  output logic [DataWidth-1:0]              bf_data_o,
  output logic                              bf_reset_o,
  input  logic                              bf_match_i,
  output logic [$clog2(MaxInserts+1)-1:0]   count_o,
  output logic                              full_o,
  output logic                              busy_o
);

  localparam int CntW  = $clog2(MaxInserts + 1);
  localparam int WaitW = (CheckLatency > 1) ? $clog2(CheckLatency) : 1;
  localparam int ClrW  = $clog2(ClearCycles + 1);

  typedef enum logic [2:0] {
    S_CLEAR,
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t               state_q, state_d;
  logic [ClrW-1:0]      clr_cnt_q;
  logic [WaitW-1:0]     wait_q;
  logic                 pend_q;
  logic                 ptr_q;
  logic                 sel_q;
  logic                 op_q;
  logic [DataWidth-1:0] data_q;
  logic                 match_q;
  logic                 err_q;
  logic [CntW-1:0]      count_q;
  logic                 done_q;
  logic                 sel;
  logic                 clear_now;

  // A clear request seen now or latched earlier wins over any new grant.
  assign clear_now = pend_q | clear_req_i;

  // Round-robin pick: the pointer only breaks ties when both request.
  assign sel = (req_i == 2'b11) ? ptr_q : req_i[1];

  // Next-state decode and the combinational grant pulse.
  always_comb begin
    state_d = state_q;
    gnt_o   = 2'b00;
    case (state_q)
      S_CLEAR: if (clr_cnt_q == ClrW'(1)) state_d = S_IDLE;
      S_IDLE: begin
        if (clear_now) begin
          state_d = S_CLEAR;
        end else if (req_i != 2'b00) begin
          gnt_o   = sel ? 2'b10 : 2'b01;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: state_d = op_q ? S_RESP : S_WAIT;
      S_WAIT:  if (wait_q == '0) state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_CLEAR;
    endcase
  end

  // State, transaction capture, occupancy and clear bookkeeping.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_CLEAR;
      clr_cnt_q <= ClrW'(ClearCycles);
      wait_q    <= '0;
      pend_q    <= 1'b0;
      ptr_q     <= 1'b0;
      sel_q     <= 1'b0;
      op_q      <= 1'b0;
      data_q    <= '0;
      match_q   <= 1'b0;
      err_q     <= 1'b0;
      count_q   <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_q == S_CLEAR) && (state_d == S_IDLE);

      if (state_q != S_CLEAR && state_d == S_CLEAR)
        clr_cnt_q <= ClrW'(ClearCycles);
      else if (state_q == S_CLEAR)
        clr_cnt_q <= clr_cnt_q - 1'b1;

      if (state_q == S_IDLE && state_d == S_CLEAR)
        pend_q <= 1'b0;
      else if (clear_req_i && state_q != S_IDLE && state_q != S_CLEAR)
        pend_q <= 1'b1;

      if (gnt_o != 2'b00) begin
        sel_q  <= sel;
        op_q   <= op_i[sel];
        data_q <= sel ? data1_i : data0_i;
        if (req_i == 2'b11) ptr_q <= ~sel;
      end

      case (state_q)
        S_CLEAR: count_q <= '0;
        S_ISSUE: begin
          if (op_q) begin
            match_q <= 1'b0;
            err_q   <= full_o;
            if (!full_o) count_q <= count_q + 1'b1;
          end else begin
            err_q  <= 1'b0;
            wait_q <= WaitW'(CheckLatency - 1);
          end
        end
        S_WAIT: begin
          wait_q <= wait_q - 1'b1;
          if (wait_q == '0) match_q <= bf_match_i;
        end
        default: ;
      endcase
    end
  end

  assign bf_reset_o   = (state_q == S_CLEAR);
  assign busy_o       = (state_q != S_IDLE);
  assign bf_insert_o  = (state_q == S_ISSUE) && op_q && !full_o;
  assign bf_check_o   = (state_q == S_ISSUE) && !op_q;
  assign bf_data_o    = data_q;
  assign rsp_valid_o  = (state_q == S_RESP) ? (sel_q ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_match_o  = (state_q == S_RESP) && match_q;
  assign rsp_err_o    = (state_q == S_RESP) && err_q;
  assign clear_done_o = done_q;
  assign count_o      = (state_q == S_CLEAR) ? '0 : count_q;
  assign full_o       = (count_o == CntW'(MaxInserts));

endmodule
